// File: rtl/audio_pkg.sv
// Shared types for the audio SRAM scheduler; the top-level FSM uses sched_state_t to decode state_o.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    REC_PAUSE  = 3'd2,
    PLAY       = 3'd3,
    PLAY_PAUSE = 3'd4
  } sched_state_t;

endpackage

// File: rtl/audio_sram_sched_if.sv
// Command, I2S sample and SRAM pin bundle between the top FSM/I2S block, the scheduler and the SRAM.
interface audio_sram_sched_if #(
  parameter int unsigned ADDR_W = 20
) ();

  localparam int unsigned SW = audio_pkg::SAMPLE_W;

  logic              cmd_rec;
  logic              cmd_play;
  logic              cmd_pause;
  logic              cmd_stop;
  logic [SW-1:0]     record_data;
  logic              record_valid;
  logic              request_play;
  logic [SW-1:0]     play_data;
  logic              play_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [SW-1:0]     sram_wdata;
  logic [SW-1:0]     sram_rdata;
  logic              sram_we_n;
  logic              sram_oe_n;

  // Scheduler side
  modport master (
    input  cmd_rec, cmd_play, cmd_pause, cmd_stop,
    input  record_data, record_valid, request_play, sram_rdata,
    output play_data, play_valid, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

  // Command / I2S / SRAM side
  modport slave (
    output cmd_rec, cmd_play, cmd_pause, cmd_stop,
    output record_data, record_valid, request_play, sram_rdata,
    input  play_data, play_valid, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/audio_addr_ctr.sv
// W-bit SRAM pointer with clear and increment; wrap_c flags the last address.
module audio_addr_ctr #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap_c
);

  // clr together with inc lands on 1: the access at address 0 is consumed in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign wrap_c = (cnt == {W{1'b1}});

endmodule

// File: rtl/audio_sram_sched.sv
// Arbitrates one external SRAM between I2S recording and playback; keeps the recorded length.
// Optional build macro LOOP_PLAY_EN: playback wraps to address 0 at end of data instead of stopping.
module audio_sram_sched #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  audio_sram_sched_if.master     bus,
  output logic [2:0]             state_o,
  output logic [ADDR_W-1:0]      rec_len,
  output logic                   mem_full
);
  import audio_pkg::*;

  localparam int unsigned SW = SAMPLE_W;

  localparam logic [2:0] ST_IDLE       = 3'(IDLE);
  localparam logic [2:0] ST_REC        = 3'(REC);
  localparam logic [2:0] ST_REC_PAUSE  = 3'(REC_PAUSE);
  localparam logic [2:0] ST_PLAY       = 3'(PLAY);
  localparam logic [2:0] ST_PLAY_PAUSE = 3'(PLAY_PAUSE);

  logic [2:0]        state_q, state_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     play_data_q, play_data_d;
  logic              play_valid_q, play_valid_d;
  logic [ADDR_W-1:0] rec_len_q, rec_len_d;
  logic              mem_full_q, mem_full_d;
  logic              rd_pend_q, rd_pend_d;

  logic              wr_clr, wr_inc, rd_clr, rd_inc;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_wrap_c, rd_wrap_c, rd_eod_c;

  audio_addr_ctr #(.W(ADDR_W)) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wr_clr),
    .inc    (wr_inc),
    .cnt    (wr_ptr),
    .wrap_c (wr_wrap_c)
  );

  audio_addr_ctr #(.W(ADDR_W)) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rd_clr),
    .inc    (rd_inc),
    .cnt    (rd_ptr),
    .wrap_c (rd_wrap_c)
  );

  // rd_ptr never passes rec_len; the wrap term only guards against a pointer roll-over
  assign rd_eod_c = (rd_ptr == rec_len_q) || rd_wrap_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    play_data_d  = play_data_q;
    play_valid_d = 1'b0;
    rec_len_d    = rec_len_q;
    mem_full_d   = mem_full_q;
    rd_pend_d    = 1'b0;
    wr_clr       = 1'b0;
    wr_inc       = 1'b0;
    rd_clr       = 1'b0;
    rd_inc       = 1'b0;

    if (bus.cmd_stop) begin
      state_d = ST_IDLE;
    end else if (bus.cmd_pause) begin
      case (state_q)
        ST_REC:        state_d = ST_REC_PAUSE;
        ST_REC_PAUSE:  state_d = ST_REC;
        ST_PLAY:       state_d = ST_PLAY_PAUSE;
        ST_PLAY_PAUSE: state_d = ST_PLAY;
        default:       ;
      endcase
    end else if (state_q == ST_IDLE) begin
      if (bus.cmd_rec) begin
        state_d    = ST_REC;
        wr_clr     = 1'b1;
        rec_len_d  = '0;
        mem_full_d = 1'b0;
      end else if (bus.cmd_play && (rec_len_q != '0)) begin
        state_d = ST_PLAY;
        rd_clr  = 1'b1;
      end
    end

    // A sample seen in REC is written even alongside stop/pause
    if ((state_q == ST_REC) && bus.record_valid) begin
      we_n_d  = 1'b0;
      addr_d  = wr_ptr;
      wdata_d = bus.record_data;
      wr_inc  = 1'b1;
      if (wr_wrap_c) begin
        mem_full_d = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        rec_len_d = ADDR_W'(rec_len_q + 1'b1);
      end
    end

    // Read data is sampled at the end of the oe_n-low cycle unless a stop cancels it
    if (rd_pend_q && !bus.cmd_stop) begin
      play_data_d  = bus.sram_rdata;
      play_valid_d = 1'b1;
    end

    if ((state_q == ST_PLAY) && bus.request_play && !rd_pend_q && !bus.cmd_stop) begin
      if (!rd_eod_c) begin
        oe_n_d    = 1'b0;
        addr_d    = rd_ptr;
        rd_inc    = 1'b1;
        rd_pend_d = 1'b1;
      end else begin
`ifdef LOOP_PLAY_EN
        oe_n_d    = 1'b0;
        addr_d    = '0;
        rd_clr    = 1'b1;
        rd_inc    = 1'b1;
        rd_pend_d = 1'b1;
`else
        state_d   = ST_IDLE;
`endif
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      play_data_q  <= '0;
      play_valid_q <= 1'b0;
      rec_len_q    <= '0;
      mem_full_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      play_data_q  <= play_data_d;
      play_valid_q <= play_valid_d;
      rec_len_q    <= rec_len_d;
      mem_full_q   <= mem_full_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.play_data  = play_data_q;
  assign bus.play_valid = play_valid_q;
  assign state_o        = state_q;
  assign rec_len        = rec_len_q;
  assign mem_full       = mem_full_q;

endmodule

// File: tb/tb_audio_sram_sched.sv
// Directed + randomized bench for audio_sram_sched at ADDR_W=3 with a behavioural SRAM and recording model.
module tb_audio_sram_sched;
  import audio_pkg::*;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [2:0]    state_o;
  logic [AW-1:0] rec_len;
  logic          mem_full;

  audio_sram_sched_if #(.ADDR_W(AW)) bus ();

  audio_sram_sched #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_o  (state_o),
    .rec_len  (rec_len),
    .mem_full (mem_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous-read SRAM
  logic [15:0] mem [DEPTH];
  always @(posedge clk) if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_wdata;
  assign bus.sram_rdata = bus.sram_oe_n ? 16'h0000 : mem[bus.sram_addr];

  typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  wr_t         wlog[$];
  logic [15:0] plog[$];
  int          oe_cnt   = 0;
  int          both_low = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.sram_we_n) wlog.push_back({bus.sram_addr, bus.sram_wdata});
      if (!bus.sram_oe_n) oe_cnt++;
      if (bus.play_valid) plog.push_back(bus.play_data);
      if (!bus.sram_we_n && !bus.sram_oe_n) both_low++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // c = {stop, pause, play, rec}
  task automatic cmd(input logic [3:0] c);
    {bus.cmd_stop, bus.cmd_pause, bus.cmd_play, bus.cmd_rec} = c;
    tick(1);
    {bus.cmd_stop, bus.cmd_pause, bus.cmd_play, bus.cmd_rec} = 4'b0000;
  endtask

  task automatic sample(input logic [15:0] d);
    bus.record_valid = 1'b1;
    bus.record_data  = d;
    tick(1);
    bus.record_valid = 1'b0;
  endtask

  task automatic req();
    bus.request_play = 1'b1;
    tick(1);
    bus.request_play = 1'b0;
  endtask

  localparam logic [3:0] C_REC = 4'b0001, C_PLAY = 4'b0010, C_PAUSE = 4'b0100, C_STOP = 4'b1000;

  initial begin
    logic [15:0] smp[$];
    logic [15:0] d;
    int base, pb, ocnt, k, nwr, exp_len, nplay;
    logic full;

    rst_n = 1'b0;
    {bus.cmd_stop, bus.cmd_pause, bus.cmd_play, bus.cmd_rec} = 4'b0000;
    bus.record_valid = 1'b0;
    bus.record_data  = 16'h0000;
    bus.request_play = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    check("rst_state", 32'(state_o), 32'(IDLE));
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("rst_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_wdata", 32'(bus.sram_wdata), 32'd0);
    check("rst_play_data", 32'(bus.play_data), 32'd0);
    check("rst_play_valid", 32'(bus.play_valid), 32'd0);
    check("rst_rec_len", 32'(rec_len), 32'd0);
    check("rst_mem_full", 32'(mem_full), 32'd0);

    cmd(C_PLAY);
    check("play_empty_stays_idle", 32'(state_o), 32'(IDLE));

    // Record four samples then stop
    cmd(C_REC);
    check("t1_state_rec", 32'(state_o), 32'(REC));
    for (int i = 0; i < 4; i++) begin
      d = 16'(32'h1111 * (i + 1));
      sample(d);
      check("t1_we_n", 32'(bus.sram_we_n), 32'd0);
      check("t1_addr", 32'(bus.sram_addr), 32'(i));
      check("t1_wdata", 32'(bus.sram_wdata), 32'(d));
      tick(1);
    end
    cmd(C_STOP);
    check("t1_state_idle", 32'(state_o), 32'(IDLE));
    check("t1_rec_len", 32'(rec_len), 32'd4);
    check("t1_mem_full", 32'(mem_full), 32'd0);

    // Play back with requests three cycles apart
    cmd(C_PLAY);
    check("t2_state_play", 32'(state_o), 32'(PLAY));
    for (int i = 0; i < 5; i++) begin
      req();
      if (i < 4) begin
        check("t2_oe_n", 32'(bus.sram_oe_n), 32'd0);
        check("t2_addr", 32'(bus.sram_addr), 32'(i));
        tick(1);
        check("t2_play_valid", 32'(bus.play_valid), 32'd1);
        check("t2_play_data", 32'(bus.play_data), 32'(16'(32'h1111 * (i + 1))));
        tick(1);
      end else begin
`ifdef LOOP_PLAY_EN
        check("t2_loop_addr", 32'(bus.sram_addr), 32'd0);
        tick(1);
        check("t2_loop_valid", 32'(bus.play_valid), 32'd1);
        check("t2_loop_data", 32'(bus.play_data), 32'h1111);
        cmd(C_STOP);
`else
        check("t2_eod_state", 32'(state_o), 32'(IDLE));
        check("t2_eod_oe_n", 32'(bus.sram_oe_n), 32'd1);
        tick(1);
        check("t2_eod_no_valid", 32'(bus.play_valid), 32'd0);
`endif
      end
    end
    check("t2_rec_len_kept", 32'(rec_len), 32'd4);

    // Pause during recording drops samples and keeps the write pointer
    base = wlog.size();
    cmd(C_REC);
    sample(16'hA000);
    sample(16'hA001);
    cmd(C_PAUSE);
    check("t4_state_pause", 32'(state_o), 32'(REC_PAUSE));
    sample(16'hBAD0);
    sample(16'hBAD1);
    cmd(C_PAUSE);
    check("t4_state_resume", 32'(state_o), 32'(REC));
    sample(16'hC002);
    cmd(C_STOP);
    tick(2);
    check("t4_write_count", 32'(wlog.size() - base), 32'd3);
    check("t4_resume_write", 32'(wlog[base + 2]), 32'({AW'(2), 16'hC002}));
    check("t4_rec_len", 32'(rec_len), 32'd3);

    // Back-to-back request is ignored; stop cancels an outstanding read
    cmd(C_PLAY);
    ocnt = oe_cnt;
    pb   = plog.size();
    req();
    req();
    tick(2);
    check("t5_single_oe", 32'(oe_cnt - ocnt), 32'd1);
    check("t5_single_play", 32'(plog.size() - pb), 32'd1);
    check("t5_play_data", 32'(plog[plog.size() - 1]), 32'hA000);
    req();
    check("t5_oe_n", 32'(bus.sram_oe_n), 32'd0);
    check("t5_addr", 32'(bus.sram_addr), 32'd1);
    bus.cmd_stop = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    check("t5_cancel_valid", 32'(bus.play_valid), 32'd0);
    check("t5_state_idle", 32'(state_o), 32'(IDLE));
    tick(2);
    check("t5_no_late_play", 32'(plog.size() - pb), 32'd1);

    // Sample with simultaneous stop is written; async reset mid-play clears everything
    cmd(C_REC);
    bus.record_valid = 1'b1;
    bus.record_data  = 16'h5A5A;
    bus.cmd_stop     = 1'b1;
    tick(1);
    bus.record_valid = 1'b0;
    bus.cmd_stop     = 1'b0;
    check("t6_we_n", 32'(bus.sram_we_n), 32'd0);
    check("t6_wdata", 32'(bus.sram_wdata), 32'h5A5A);
    check("t6_state_idle", 32'(state_o), 32'(IDLE));
    check("t6_rec_len", 32'(rec_len), 32'd1);
    cmd(C_PLAY);
    req();
    check("t6_oe_before_rst", 32'(bus.sram_oe_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(state_o), 32'(IDLE));
    check("t6_rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("t6_rst_rec_len", 32'(rec_len), 32'd0);
    check("t6_rst_addr", 32'(bus.sram_addr), 32'd0);
    tick(1);
    check("t6_rst_play_valid", 32'(bus.play_valid), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Randomized record/playback against the length/capacity model; first pass overflows
    for (int t = 0; t < 6; t++) begin
      k = (t == 0) ? 9 : int'($urandom_range(1, 10));
      smp.delete();
      for (int j = 0; j < k; j++) smp.push_back(16'($urandom));
      nwr     = (k < DEPTH) ? k : DEPTH;
      exp_len = (k < DEPTH) ? k : DEPTH - 1;
      full    = (k >= DEPTH);

      base = wlog.size();
      cmd(C_REC);
      for (int j = 0; j < k; j++) begin
        sample(smp[j]);
        tick(int'($urandom_range(0, 2)));
      end
      cmd(C_STOP);
      tick(2);
      check("rnd_write_count", 32'(wlog.size() - base), 32'(nwr));
      for (int j = 0; j < nwr && (base + j) < wlog.size(); j++)
        check("rnd_write", 32'(wlog[base + j]), 32'({AW'(j), smp[j]}));
      check("rnd_rec_len", 32'(rec_len), 32'(exp_len));
      check("rnd_mem_full", 32'(mem_full), 32'(full));
      check("rnd_state_idle", 32'(state_o), 32'(IDLE));

      pb = plog.size();
      cmd(C_PLAY);
      for (int j = 0; j <= exp_len; j++) begin
        req();
        tick(int'($urandom_range(1, 3)));
      end
`ifdef LOOP_PLAY_EN
      nplay = exp_len + 1;
      cmd(C_STOP);
`else
      nplay = exp_len;
`endif
      tick(2);
      check("rnd_play_count", 32'(plog.size() - pb), 32'(nplay));
      for (int j = 0; j < nplay && (pb + j) < plog.size(); j++)
        check("rnd_play_data", 32'(plog[pb + j]), 32'(smp[j % exp_len]));
      check("rnd_play_end_idle", 32'(state_o), 32'(IDLE));
    end

    check("we_oe_exclusive", 32'(both_low), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
